uart_tx_sched: RTL and testbench

Transmit scheduler in front of `uart_tx`. It accepts bytes from two requesters under round-robin arbitration and buffers them in a small FIFO. It sequences `uart_tx` one frame at a time with a single-cycle launch strobe, waiting for the finish flag before the next launch. It also owns the baud-select setting and applies changes only between frames.

---
 rtl/uart_defs.sv | 19 +
 rtl/uart_sync_fifo.sv | 64 ++++++
 rtl/uart_tx_sched.sv | 141 ++++++++++++++
 tb/tb_uart_tx_sched.sv | 305 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_defs.sv
// Shared UART definitions: scheduler FSM state encodings and baud-select codes.
// Used by uart_tx_sched, uart_tx and uart_rx.
package uart_defs;

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StLaunch = 2'd1,
        StWait   = 2'd2
    } tx_state_e;

    typedef logic [2:0] bps_t;

    localparam bps_t Bps9600   = 3'd0;
    localparam bps_t Bps19200  = 3'd1;
    localparam bps_t Bps38400  = 3'd2;
    localparam bps_t Bps57600  = 3'd3;
    localparam bps_t Bps115200 = 3'd4;

endpackage

// File: rtl/uart_sync_fifo.sv
// Single-clock FIFO with registered full/empty and an occupancy count.
// Full rejects a push even when a pop happens in the same cycle.
module uart_sync_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 8
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     push_i,
    input  logic [WIDTH-1:0]         push_data_i,
    input  logic                     pop_i,
    output logic [WIDTH-1:0]         head_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   level_o
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [AW:0]      level_q, level_d;
    logic             full_q, empty_q;
    logic             do_push, do_pop;

    assign do_push = push_i && !full_q;
    assign do_pop  = pop_i && !empty_q;

    always_comb begin
        level_d = level_q;
        if (do_push && !do_pop) begin
            level_d = level_q + (AW+1)'(1);
        end else if (!do_push && do_pop) begin
            level_d = level_q - (AW+1)'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
            level_q <= level_d;
            full_q  <= (level_d == (AW+1)'(DEPTH));
            empty_q <= (level_d == '0);
        end
    end

    // Storage has no reset; occupancy is tracked by the pointers.
    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wr_ptr_q] <= push_data_i;
    end

    assign head_o  = mem_q[rd_ptr_q];
    assign full_o  = full_q;
    assign empty_o = empty_q;
    assign level_o = level_q;

endmodule

// File: rtl/uart_tx_sched.sv
// Round-robin two-requester transmit scheduler in front of uart_tx: buffers bytes,
// launches one frame at a time, times out stuck frames and applies baud changes between frames.
module uart_tx_sched
    import uart_defs::*;
#(
    parameter int unsigned FIFO_DEPTH  = 8,
    parameter int unsigned TIMEOUT_CYC = 524288,
    parameter logic [2:0]  BPS_RST     = 3'd2
) (
    input  logic                          i_sys_clk,
    input  logic                          i_sys_rst,
    input  logic                          i_req0_valid,
    input  logic [7:0]                    i_req0_data,
    output logic                          o_req0_ready,
    input  logic                          i_req1_valid,
    input  logic [7:0]                    i_req1_data,
    output logic                          o_req1_ready,
    input  logic                          i_cfg_wr,
    input  logic [2:0]                    i_cfg_bps,
    output logic [7:0]                    o_tx_data,
    output logic                          o_tx_flag,
    output logic [2:0]                    o_tx_bps,
    input  logic                          i_tx_finsh,
    input  logic                          i_err_clr,
    output logic                          o_busy,
    output logic [$clog2(FIFO_DEPTH):0]   o_fifo_level,
    output logic                          o_timeout_err
);

    localparam int unsigned TW = $clog2(TIMEOUT_CYC);

    tx_state_e   state_q, state_d;
    logic [TW-1:0] cnt_q, cnt_d;
    logic [7:0]  data_q, data_d;
    logic        last_q;
    logic        err_q;
    logic        pend_q;
    bps_t        pend_bps_q, bps_q;

    logic        grant0, grant1;
    logic        fifo_full, fifo_empty;
    logic        push, pop, apply, to_set;
    logic [7:0]  push_data, head;

    // last_q = 1 means the previous accepted write came from req1.
    assign grant0       = i_req0_valid && (!i_req1_valid || last_q);
    assign grant1       = i_req1_valid && !grant0;
    assign o_req0_ready = grant0 && !fifo_full;
    assign o_req1_ready = grant1 && !fifo_full;
    assign push         = (i_req0_valid && o_req0_ready) || (i_req1_valid && o_req1_ready);
    assign push_data    = grant0 ? i_req0_data : i_req1_data;

    uart_sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i       (i_sys_clk),
        .rst_i       (i_sys_rst),
        .push_i      (push),
        .push_data_i (push_data),
        .pop_i       (pop),
        .head_o      (head),
        .full_o      (fifo_full),
        .empty_o     (fifo_empty),
        .level_o     (o_fifo_level)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        data_d  = data_q;
        pop     = 1'b0;
        apply   = 1'b0;
        to_set  = 1'b0;
        unique case (state_q)
            StIdle: begin
                // A pending baud change is applied before the next frame starts.
                if (pend_q) begin
                    apply = 1'b1;
                end else if (!fifo_empty) begin
                    pop     = 1'b1;
                    data_d  = head;
                    state_d = StLaunch;
                end
            end
            StLaunch: begin
                cnt_d   = '0;
                state_d = StWait;
            end
            StWait: begin
                if (i_tx_finsh) begin
                    state_d = StIdle;
                end else if (cnt_q == TW'(TIMEOUT_CYC - 1)) begin
                    to_set  = 1'b1;
                    state_d = StIdle;
                end else begin
                    cnt_d = cnt_q + TW'(1);
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge i_sys_clk) begin
        if (i_sys_rst) begin
            state_q    <= StIdle;
            cnt_q      <= '0;
            data_q     <= 8'h00;
            last_q     <= 1'b1;
            err_q      <= 1'b0;
            pend_q     <= 1'b0;
            pend_bps_q <= BPS_RST;
            bps_q      <= BPS_RST;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            data_q  <= data_d;
            if (push) last_q <= grant1;
            if (to_set) begin
                err_q <= 1'b1;
            end else if (i_err_clr) begin
                err_q <= 1'b0;
            end
            if (apply) bps_q <= pend_bps_q;
            // A new write in the apply cycle re-arms the pending bit with the new value.
            if (i_cfg_wr) begin
                pend_q     <= 1'b1;
                pend_bps_q <= i_cfg_bps;
            end else if (apply) begin
                pend_q <= 1'b0;
            end
        end
    end

    assign o_tx_data     = data_q;
    assign o_tx_flag     = (state_q == StLaunch);
    assign o_tx_bps      = bps_q;
    assign o_busy        = (state_q != StIdle) || !fifo_empty;
    assign o_timeout_err = err_q;

endmodule

// File: tb/tb_uart_tx_sched.sv
// Directed self-checking bench for uart_tx_sched: reset, latency, round-robin,
// full FIFO, baud change, timeout/error clear and mid-frame reset.
module tb_uart_tx_sched;

    localparam int unsigned DEPTH = 8;
    localparam int unsigned TO    = 128;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       v0 = 1'b0, v1 = 1'b0;
    logic [7:0] d0 = 8'h00, d1 = 8'h00;
    logic       rdy0, rdy1;
    logic       cfg_wr = 1'b0;
    logic [2:0] cfg_bps = 3'd0;
    logic [7:0] tx_data;
    logic       tx_flag;
    logic [2:0] tx_bps;
    logic       finsh = 1'b0;
    logic       err_clr = 1'b0;
    logic       busy;
    logic [3:0] level;
    logic       terr;

    always #5 clk = ~clk;

    uart_tx_sched #(
        .FIFO_DEPTH  (DEPTH),
        .TIMEOUT_CYC (TO),
        .BPS_RST     (3'd2)
    ) dut (
        .i_sys_clk     (clk),
        .i_sys_rst     (rst),
        .i_req0_valid  (v0),
        .i_req0_data   (d0),
        .o_req0_ready  (rdy0),
        .i_req1_valid  (v1),
        .i_req1_data   (d1),
        .o_req1_ready  (rdy1),
        .i_cfg_wr      (cfg_wr),
        .i_cfg_bps     (cfg_bps),
        .o_tx_data     (tx_data),
        .o_tx_flag     (tx_flag),
        .o_tx_bps      (tx_bps),
        .i_tx_finsh    (finsh),
        .i_err_clr     (err_clr),
        .o_busy        (busy),
        .o_fifo_level  (level),
        .o_timeout_err (terr)
    );

    int unsigned n_chk = 0;
    int unsigned n_bad = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    logic       prev_flag;
    logic [7:0] launch_q[$];
    logic [7:0] acc_q[$];

    // Record launches and accepted writes; a launch right after a launch is an error.
    always @(posedge clk) begin
        if (rst) begin
            prev_flag <= 1'b0;
        end else begin
            if (tx_flag) begin
                check("flag_gap", prev_flag, 1'b0);
                launch_q.push_back(tx_data);
            end
            prev_flag <= tx_flag;
            if (v0 && rdy0) acc_q.push_back(d0);
            if (v1 && rdy1) acc_q.push_back(d1);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        v0 = 1'b0; v1 = 1'b0; cfg_wr = 1'b0; finsh = 1'b0; err_clr = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        launch_q.delete();
        acc_q.delete();
    endtask

    // Wait for each launch, then finish that frame once it reaches WAIT.
    task automatic drain(input int n);
        for (int i = 0; i < n; i++) begin
            int w = 0;
            while (!tx_flag && w < 20) begin
                tick();
                w++;
            end
            check("drain_flag", tx_flag, 1'b1);
            tick();
            finsh = 1'b1;
            tick();
            finsh = 1'b0;
        end
    endtask

    initial begin
        #100000;
        $display("FAIL global_timeout: got=running exp=finished");
        $fatal(1);
    end

    initial begin
        logic [7:0] rr_exp [8];
        int n0, n1, idx, nl;
        logic a0, a1;

        // Reset state
        do_reset();
        check("rst_flag", tx_flag, 1'b0);
        check("rst_data", tx_data, 8'h00);
        check("rst_bps", tx_bps, 3'd2);
        check("rst_err", terr, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_level", level, 4'd0);
        v0 = 1'b1; v1 = 1'b1;
        #1;
        check("rst_rdy0", rdy0, 1'b1);
        check("rst_rdy1", rdy1, 1'b0);
        v0 = 1'b0; v1 = 1'b0;

        // Single byte latency
        do_reset();
        v0 = 1'b1; d0 = 8'hA5;
        #1;
        check("sb_rdy", rdy0, 1'b1);
        tick();
        v0 = 1'b0;
        check("sb_level", level, 4'd1);
        check("sb_busy", busy, 1'b1);
        check("sb_noflag", tx_flag, 1'b0);
        tick();
        check("sb_flag", tx_flag, 1'b1);
        check("sb_data", tx_data, 8'hA5);
        check("sb_level0", level, 4'd0);
        tick();
        check("sb_flag_off", tx_flag, 1'b0);
        check("sb_busy_wait", busy, 1'b1);
        repeat (97) tick();
        finsh = 1'b1;
        tick();
        finsh = 1'b0;
        check("sb_idle", busy, 1'b0);
        check("sb_hold", tx_data, 8'hA5);
        check("sb_launches", launch_q.size(), 1);
        check("sb_err", terr, 1'b0);

        // Round-robin
        do_reset();
        rr_exp = '{8'h10, 8'h20, 8'h11, 8'h21, 8'h12, 8'h22, 8'h13, 8'h23};
        n0 = 0; n1 = 0;
        for (int c = 0; c < 40 && (n0 < 4 || n1 < 4); c++) begin
            v0 = (n0 < 4); v1 = (n1 < 4);
            d0 = 8'h10 + 8'(n0); d1 = 8'h20 + 8'(n1);
            #1;
            a0 = v0 && rdy0;
            a1 = v1 && rdy1;
            tick();
            if (a0) n0++;
            if (a1) n1++;
        end
        v0 = 1'b0; v1 = 1'b0;
        check("rr_count", acc_q.size(), 8);
        for (int i = 0; i < 8 && i < acc_q.size(); i++) check("rr_acc", acc_q[i], rr_exp[i]);
        finsh = 1'b1;
        tick();
        finsh = 1'b0;
        drain(7);
        check("rr_launch_cnt", launch_q.size(), 8);
        for (int i = 0; i < 8 && i < launch_q.size(); i++) check("rr_tx", launch_q[i], rr_exp[i]);
        check("rr_idle", busy, 1'b0);

        // Full FIFO with finish withheld
        do_reset();
        idx = 0;
        for (int c = 0; c < 15; c++) begin
            v0 = (idx < 10);
            d0 = 8'h30 + 8'(idx);
            #1;
            a0 = v0 && rdy0;
            tick();
            if (a0) idx++;
        end
        check("full_acc", idx, 9);
        check("full_level", level, 4'd8);
        check("full_rdy", rdy0, 1'b0);
        finsh = 1'b1;
        tick();
        finsh = 1'b0;
        check("full_fin_level", level, 4'd8);
        check("full_fin_rdy", rdy0, 1'b0);
        tick();
        check("full_pop_level", level, 4'd7);
        check("full_pop_rdy", rdy0, 1'b1);
        check("full_pop_flag", tx_flag, 1'b1);
        check("full_pop_data", tx_data, 8'h31);
        tick();
        v0 = 1'b0;
        check("full_refill", level, 4'd8);
        check("full_total", acc_q.size(), 10);

        // Baud change during a frame
        do_reset();
        v0 = 1'b1; d0 = 8'h55;
        tick();
        d0 = 8'h66;
        tick();
        v0 = 1'b0;
        check("bd_flag", tx_flag, 1'b1);
        check("bd_data", tx_data, 8'h55);
        tick();
        cfg_wr = 1'b1; cfg_bps = 3'd4;
        tick();
        cfg_wr = 1'b0;
        check("bd_hold1", tx_bps, 3'd2);
        repeat (3) tick();
        check("bd_hold2", tx_bps, 3'd2);
        finsh = 1'b1;
        tick();
        finsh = 1'b0;
        check("bd_fin_bps", tx_bps, 3'd2);
        check("bd_fin_flag", tx_flag, 1'b0);
        tick();
        check("bd_apply", tx_bps, 3'd4);
        check("bd_apply_flag", tx_flag, 1'b0);
        tick();
        check("bd_late_flag", tx_flag, 1'b1);
        check("bd_late_data", tx_data, 8'h66);
        check("bd_keep", tx_bps, 3'd4);

        // Timeout and error clear
        do_reset();
        v0 = 1'b1; d0 = 8'h77;
        tick();
        d0 = 8'h78;
        tick();
        v0 = 1'b0;
        check("to_launch", tx_flag, 1'b1);
        tick();
        repeat (TO - 1) tick();
        check("to_early", terr, 1'b0);
        tick();
        check("to_set", terr, 1'b1);
        tick();
        check("to_next_flag", tx_flag, 1'b1);
        check("to_next_data", tx_data, 8'h78);
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        check("to_clr", terr, 1'b0);
        repeat (TO - 1) tick();
        check("to_early2", terr, 1'b0);
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        check("to_set_wins", terr, 1'b1);

        // Reset mid-frame
        do_reset();
        cfg_wr = 1'b1; cfg_bps = 3'd5;
        tick();
        cfg_wr = 1'b0;
        tick();
        check("mr_bps", tx_bps, 3'd5);
        for (int i = 0; i < 4; i++) begin
            v0 = 1'b1; d0 = 8'h81 + 8'(i);
            tick();
        end
        v0 = 1'b0;
        check("mr_level", level, 4'd3);
        check("mr_busy", busy, 1'b1);
        nl = launch_q.size();
        rst = 1'b1;
        tick();
        check("mr_flag", tx_flag, 1'b0);
        check("mr_data", tx_data, 8'h00);
        check("mr_bps_rst", tx_bps, 3'd2);
        check("mr_err", terr, 1'b0);
        check("mr_busy0", busy, 1'b0);
        check("mr_level0", level, 4'd0);
        rst = 1'b0;
        repeat (10) tick();
        check("mr_no_launch", launch_q.size(), nl);
        check("mr_idle", busy, 1'b0);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
